// File: rtl/quant_sched_pkg.sv
// Shared definitions for the quant_sched sequencer: quantizer mode encodings,
// datapath geometry defaults and the watchdog limit.
`ifndef QSCHED_WDOG_LIM
`define QSCHED_WDOG_LIM 4096
`endif

package quant_sched_pkg;

  typedef enum logic [1:0] {
    INT4_VSQ = 2'd0,
    INT4     = 2'd1,
    INT8     = 2'd2
  } qmode_e;

  localparam int DEF_TRUNC_W   = 8;
  localparam int DEF_VL        = 32;
  localparam int DEF_ADDR_W    = 10;
  localparam int DEF_COL       = 64;
  localparam int DEF_VSQ_BUF_D = 16;
  localparam int DEF_MAX_LAT   = 4;

`ifdef QSCHED_WDOG_EN
  localparam int QSCHED_WDOG_LIM = `QSCHED_WDOG_LIM;
`endif

  // Vector-scaled INT4 scans and quantizes one group at a time; the other
  // modes scan the whole tensor first to find its max.
  function automatic logic is_vsq(input logic [1:0] m);
    return m == INT4_VSQ;
  endfunction

endpackage

// File: rtl/quant_sched_if.sv
// Command, source-buffer and quantizer signal bundle for quant_sched.
interface quant_sched_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 256
);
  // Commands transfer on a cycle where i_cmd_valid and o_cmd_ready are both
  // high; o_cmd_ready is high exactly while the sequencer is idle, so a
  // requester may hold i_cmd_valid and only one command is taken per tensor.
  logic              i_cmd_valid;
  logic              o_cmd_ready;
  logic [1:0]        i_cmd_mode;
  logic              o_src_re;
  logic [ADDR_W-1:0] o_src_addr;
  logic [DATA_W-1:0] i_src_data;
  logic [DATA_W-1:0] o_q_data;
  logic [1:0]        o_q_mode;
  logic              o_q_start;
  logic              o_q_max_done;
  logic              i_q_vec_done;
  logic              i_q_finish;
  logic              o_busy;
  logic              o_done;
  logic              o_err;

  modport slave (
    input  i_cmd_valid, i_cmd_mode, i_src_data, i_q_vec_done, i_q_finish,
    output o_cmd_ready, o_src_re, o_src_addr, o_q_data, o_q_mode, o_q_start,
           o_q_max_done, o_busy, o_done, o_err
  );

  modport master (
    output i_cmd_valid, i_cmd_mode, i_src_data, i_q_vec_done, i_q_finish,
    input  o_cmd_ready, o_src_re, o_src_addr, o_q_data, o_q_mode, o_q_start,
           o_q_max_done, o_busy, o_done, o_err
  );
endinterface

// File: rtl/quant_sched_src_align.sv
// Aligns source-buffer data with its read enable (1-cycle read latency) and
// zeroes the data path on every cycle that carries no valid beat.
module quant_sched_src_align #(
  parameter int DATA_W = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              re,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] q_data
);

  logic re_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) re_d <= 1'b0;
    else        re_d <= re;
  end

  // Masking keeps stale buffer contents out of the quantizer's running max.
  assign q_data = data & {DATA_W{re_d}};

endmodule

// File: rtl/quant_sched.sv
// Sequencer that streams one tensor per command from the source buffer into
// the quantizer. Optional watchdog on the QUANT wait: define QSCHED_WDOG_EN.
module quant_sched
  import quant_sched_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int COL     = DEF_COL,
  parameter int VSQ_D   = DEF_VSQ_BUF_D,
  parameter int MAX_LAT = DEF_MAX_LAT,
  parameter int DATA_W  = DEF_TRUNC_W * DEF_VL
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  quant_sched_if.slave bus,
  output logic [2:0]  dbg_state
);

  localparam int NGRP  = COL / VSQ_D;
  localparam int GRP_W = $clog2(NGRP + 1);
  localparam int CNT_W = $clog2(COL + MAX_LAT + 1);

  localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(NGRP);
  localparam logic [CNT_W-1:0] VSQ_LAST = CNT_W'(VSQ_D - 1);
  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(COL - 1);
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(MAX_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SCAN   = 3'd1,
    S_WAIT   = 3'd2,
    S_REDUCE = 3'd3,
    S_QUANT  = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  state_e            state, state_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic [CNT_W-1:0]  bcnt, bcnt_n;
  logic [GRP_W-1:0]  grp, grp_n, grp_inc;
  logic [1:0]        mode, mode_n;
  logic              src_re, q_start, q_max_done, done, cmd_ready, busy;
  logic              start_n, max_done_n;
  logic              vsq, scan_last, wd_expire;

  assign vsq       = is_vsq(mode);
  assign grp_inc   = grp + GRP_W'(1);
  assign scan_last = vsq ? (bcnt == VSQ_LAST) : (bcnt == COL_LAST);

  always_comb begin
    state_n    = state;
    addr_n     = addr;
    bcnt_n     = bcnt;
    grp_n      = grp;
    mode_n     = mode;
    start_n    = 1'b0;
    max_done_n = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.i_cmd_valid && cmd_ready) begin
          mode_n  = bus.i_cmd_mode;
          addr_n  = '0;
          bcnt_n  = '0;
          grp_n   = '0;
          state_n = S_SCAN;
        end
      end
      S_SCAN: begin
        addr_n = addr + ADDR_W'(1);
        bcnt_n = bcnt + CNT_W'(1);
        if (scan_last) begin
          // Strobes are registered, so raise them for the WAIT cycle now.
          start_n    = vsq;
          max_done_n = !vsq;
          bcnt_n     = '0;
          state_n    = S_WAIT;
        end
      end
      S_WAIT: begin
        bcnt_n  = '0;
        state_n = vsq ? S_QUANT : S_REDUCE;
      end
      S_REDUCE: begin
        bcnt_n = bcnt + CNT_W'(1);
        if (bcnt == LAT_LAST) begin
          start_n = 1'b1;
          bcnt_n  = '0;
          state_n = S_QUANT;
        end
      end
      S_QUANT: begin
        if (grp == GRP_LAST) begin
          if (bus.i_q_finish) state_n = S_DONE;
        end else if (bus.i_q_vec_done) begin
          grp_n = grp_inc;
          if (grp_inc == GRP_LAST) begin
            if (bus.i_q_finish) state_n = S_DONE;
          end else if (vsq) begin
            bcnt_n  = '0;
            state_n = S_SCAN;
          end else begin
            start_n = 1'b1;
          end
        end
        if (wd_expire) begin
          start_n = 1'b0;
          state_n = S_IDLE;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      addr       <= '0;
      bcnt       <= '0;
      grp        <= '0;
      mode       <= 2'd0;
      src_re     <= 1'b0;
      q_start    <= 1'b0;
      q_max_done <= 1'b0;
      done       <= 1'b0;
      cmd_ready  <= 1'b1;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      addr       <= addr_n;
      bcnt       <= bcnt_n;
      grp        <= grp_n;
      mode       <= mode_n;
      src_re     <= (state_n == S_SCAN);
      q_start    <= start_n;
      q_max_done <= max_done_n;
      done       <= (state_n == S_DONE);
      cmd_ready  <= (state_n == S_IDLE);
      busy       <= (state_n != S_IDLE);
    end
  end

`ifdef QSCHED_WDOG_EN
  logic [15:0] wd;
  logic        err;

  // Only a silent quantizer in QUANT ages the watchdog.
  assign wd_expire = (state == S_QUANT) && !bus.i_q_vec_done && !bus.i_q_finish &&
                     (wd == 16'(QSCHED_WDOG_LIM - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wd  <= '0;
      err <= 1'b0;
    end else begin
      err <= wd_expire;
      if (state != S_QUANT || bus.i_q_vec_done || bus.i_q_finish) wd <= '0;
      else                                                         wd <= wd + 16'd1;
    end
  end

  assign bus.o_err = err;
`else
  assign wd_expire = 1'b0;
  assign bus.o_err = 1'b0;
`endif

  quant_sched_src_align #(.DATA_W(DATA_W)) u_align (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .re     (src_re),
    .data   (bus.i_src_data),
    .q_data (bus.o_q_data)
  );

  assign bus.o_cmd_ready  = cmd_ready;
  assign bus.o_src_re     = src_re;
  assign bus.o_src_addr   = addr;
  assign bus.o_q_mode     = mode;
  assign bus.o_q_start    = q_start;
  assign bus.o_q_max_done = q_max_done;
  assign bus.o_busy       = busy;
  assign bus.o_done       = done;
  assign dbg_state        = state;

endmodule
